// File: rtl/conv_transposed_2d_tap_scheduler.sv
// Tap sequencer for gather-form transposed 2-D convolution: walks oc/oh/ow/ic/kh/kw
// and issues one registered MAC command per tap, resolving stride and padding locally.
module conv_transposed_2d_tap_scheduler #(
   parameter int IN_H     = 4,
   parameter int IN_W     = 4,
   parameter int K_H      = 3,
   parameter int K_W      = 3,
   parameter int STRIDE_H = 2,
   parameter int STRIDE_W = 2,
   parameter int PAD_H    = 1,
   parameter int PAD_W    = 1,
   parameter int C_IN     = 2,
   parameter int C_OUT    = 2,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [ADDR_W-1:0] cmd_in_addr,
   output logic [ADDR_W-1:0] cmd_w_addr,
   output logic [ADDR_W-1:0] cmd_out_addr,
   output logic              cmd_tap_valid,
   output logic              cmd_first,
   output logic              cmd_last
);
   localparam int OUT_H    = (IN_H - 1) * STRIDE_H - 2 * PAD_H + K_H;
   localparam int OUT_W    = (IN_W - 1) * STRIDE_W - 2 * PAD_W + K_W;
   localparam int SH_SHIFT = $clog2(STRIDE_H);
   localparam int SW_SHIFT = $clog2(STRIDE_W);
   localparam logic [ADDR_W-1:0] ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t state_q, state_d;
   logic [ADDR_W-1:0] oc_q, oc_d, oh_q, oh_d, ow_q, ow_d;
   logic [ADDR_W-1:0] ic_q, ic_d, kh_q, kh_d, kw_q, kw_d;
   logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic              tv_q, tv_d, first_q, first_d, last_q, last_d;
   logic [ADDR_W-1:0] in_q, in_d, w_q, w_d, out_q, out_d;

   logic load, clear_cnt, advance;
   logic wrap_kw, wrap_kh, wrap_ic, wrap_ow, wrap_oh, wrap_oc;
   logic cy_kh, cy_ic, cy_ow, cy_oh, cy_oc, at_end;
   int   nh, nw, ih, iw;
   logic tap_ok, first_n, last_n;
   logic [ADDR_W-1:0] in_n, w_n, out_n;

   // Ripple-carry view of the loop nest: each counter steps when all inner ones wrap.
   always_comb begin
      wrap_kw = (kw_q == ADDR_W'(K_W - 1));
      wrap_kh = (kh_q == ADDR_W'(K_H - 1));
      wrap_ic = (ic_q == ADDR_W'(C_IN - 1));
      wrap_ow = (ow_q == ADDR_W'(OUT_W - 1));
      wrap_oh = (oh_q == ADDR_W'(OUT_H - 1));
      wrap_oc = (oc_q == ADDR_W'(C_OUT - 1));
      cy_kh   = wrap_kw;
      cy_ic   = cy_kh & wrap_kh;
      cy_ow   = cy_ic & wrap_ic;
      cy_oh   = cy_ow & wrap_ow;
      cy_oc   = cy_oh & wrap_oh;
      at_end  = cy_oc & wrap_oc;
   end

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      valid_d   = valid_q;
      load      = 1'b0;
      clear_cnt = 1'b0;
      advance   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d   = S_RUN;
               busy_d    = 1'b1;
               valid_d   = 1'b1;
               clear_cnt = 1'b1;
               load      = 1'b1;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               valid_d   = 1'b0;
               clear_cnt = 1'b1;
            end else if (valid_q && cmd_ready) begin
               if (at_end) begin
                  state_d   = S_DONE;
                  busy_d    = 1'b0;
                  valid_d   = 1'b0;
                  done_d    = 1'b1;
                  clear_cnt = 1'b1;
               end else begin
                  advance = 1'b1;
                  load    = 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      oc_d = oc_q;
      oh_d = oh_q;
      ow_d = ow_q;
      ic_d = ic_q;
      kh_d = kh_q;
      kw_d = kw_q;
      if (clear_cnt) begin
         oc_d = '0;
         oh_d = '0;
         ow_d = '0;
         ic_d = '0;
         kh_d = '0;
         kw_d = '0;
      end else if (advance) begin
         kw_d = wrap_kw ? '0 : kw_q + ONE;
         if (cy_kh) kh_d = wrap_kh ? '0 : kh_q + ONE;
         if (cy_ic) ic_d = wrap_ic ? '0 : ic_q + ONE;
         if (cy_ow) ow_d = wrap_ow ? '0 : ow_q + ONE;
         if (cy_oh) oh_d = wrap_oh ? '0 : oh_q + ONE;
         if (cy_oc) oc_d = wrap_oc ? '0 : oc_q + ONE;
      end
   end

   // Command fields are computed from the next counter values so they can be registered.
   always_comb begin
      nh      = int'(oh_d) + PAD_H - int'(kh_d);
      nw      = int'(ow_d) + PAD_W - int'(kw_d);
      ih      = nh >>> SH_SHIFT;
      iw      = nw >>> SW_SHIFT;
      tap_ok  = (nh >= 0) && (nw >= 0) &&
                ((nh & (STRIDE_H - 1)) == 0) && ((nw & (STRIDE_W - 1)) == 0) &&
                (ih < IN_H) && (iw < IN_W);
      in_n    = tap_ok ? ADDR_W'((int'(ic_d) * IN_H + ih) * IN_W + iw) : '0;
      w_n     = ADDR_W'(((int'(ic_d) * C_OUT + int'(oc_d)) * K_H + int'(kh_d)) * K_W + int'(kw_d));
      out_n   = ADDR_W'((int'(oc_d) * OUT_H + int'(oh_d)) * OUT_W + int'(ow_d));
      first_n = (ic_d == '0) && (kh_d == '0) && (kw_d == '0);
      last_n  = (ic_d == ADDR_W'(C_IN - 1)) && (kh_d == ADDR_W'(K_H - 1)) &&
                (kw_d == ADDR_W'(K_W - 1));
   end

   always_comb begin
      in_d    = in_q;
      w_d     = w_q;
      out_d   = out_q;
      tv_d    = tv_q;
      first_d = first_q;
      last_d  = last_q;
      if (load) begin
         in_d    = in_n;
         w_d     = w_n;
         out_d   = out_n;
         tv_d    = tap_ok;
         first_d = first_n;
         last_d  = last_n;
      end else if (!valid_d) begin
         in_d    = '0;
         w_d     = '0;
         out_d   = '0;
         tv_d    = 1'b0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         oc_q    <= '0;
         oh_q    <= '0;
         ow_q    <= '0;
         ic_q    <= '0;
         kh_q    <= '0;
         kw_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         in_q    <= '0;
         w_q     <= '0;
         out_q   <= '0;
         tv_q    <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         oc_q    <= oc_d;
         oh_q    <= oh_d;
         ow_q    <= ow_d;
         ic_q    <= ic_d;
         kh_q    <= kh_d;
         kw_q    <= kw_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         in_q    <= in_d;
         w_q     <= w_d;
         out_q   <= out_d;
         tv_q    <= tv_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign cmd_valid     = valid_q;
   assign cmd_in_addr   = in_q;
   assign cmd_w_addr    = w_q;
   assign cmd_out_addr  = out_q;
   assign cmd_tap_valid = tv_q;
   assign cmd_first     = first_q;
   assign cmd_last      = last_q;
endmodule

// File: tb/tb_conv_transposed_2d_tap_scheduler.sv
// Scoreboard bench for the tap scheduler: three configurations, a software loop-nest
// model fills the expected queue at start and every handshake is popped and compared.
module tb_conv_transposed_2d_tap_scheduler;
   localparam int AW = 16;

   typedef struct packed {
      logic [AW-1:0] in_a;
      logic [AW-1:0] w_a;
      logic [AW-1:0] out_a;
      logic          tv;
      logic          first;
      logic          last;
   } cmd_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, abort, cmd_ready;
   logic [2:0] start_v;
   logic          busy_a [3];
   logic          done_a [3];
   logic          valid_a[3];
   logic          tv_a   [3];
   logic          first_a[3];
   logic          last_a [3];
   logic [AW-1:0] in_a   [3];
   logic [AW-1:0] w_a    [3];
   logic [AW-1:0] out_a  [3];

   int   sel;
   logic m_busy, m_done, m_valid;
   cmd_t obs;

   always_comb begin
      m_busy  = busy_a[sel];
      m_done  = done_a[sel];
      m_valid = valid_a[sel];
      obs     = '{in_a: in_a[sel], w_a: w_a[sel], out_a: out_a[sel],
                  tv: tv_a[sel], first: first_a[sel], last: last_a[sel]};
   end

   conv_transposed_2d_tap_scheduler #(.ADDR_W(AW)) u_def (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort),
      .busy(busy_a[0]), .done(done_a[0]), .cmd_valid(valid_a[0]), .cmd_ready(cmd_ready),
      .cmd_in_addr(in_a[0]), .cmd_w_addr(w_a[0]), .cmd_out_addr(out_a[0]),
      .cmd_tap_valid(tv_a[0]), .cmd_first(first_a[0]), .cmd_last(last_a[0]));

   conv_transposed_2d_tap_scheduler #(
      .IN_H(2), .IN_W(3), .K_H(3), .K_W(2), .STRIDE_H(2), .STRIDE_W(1),
      .PAD_H(1), .PAD_W(0), .C_IN(1), .C_OUT(1), .ADDR_W(AW)) u_ref (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort),
      .busy(busy_a[1]), .done(done_a[1]), .cmd_valid(valid_a[1]), .cmd_ready(cmd_ready),
      .cmd_in_addr(in_a[1]), .cmd_w_addr(w_a[1]), .cmd_out_addr(out_a[1]),
      .cmd_tap_valid(tv_a[1]), .cmd_first(first_a[1]), .cmd_last(last_a[1]));

   conv_transposed_2d_tap_scheduler #(
      .IN_H(2), .IN_W(2), .K_H(1), .K_W(2), .STRIDE_H(1), .STRIDE_W(4),
      .PAD_H(0), .PAD_W(0), .C_IN(1), .C_OUT(1), .ADDR_W(AW)) u_emp (
      .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort),
      .busy(busy_a[2]), .done(done_a[2]), .cmd_valid(valid_a[2]), .cmd_ready(cmd_ready),
      .cmd_in_addr(in_a[2]), .cmd_w_addr(w_a[2]), .cmd_out_addr(out_a[2]),
      .cmd_tap_valid(tv_a[2]), .cmd_first(first_a[2]), .cmd_last(last_a[2]));

   int   n_checks = 0;
   int   n_errors = 0;
   cmd_t exp_q[$];
   cmd_t first6[6];
   int   hs_cnt, done_cnt, empty_cnt;
   logic any_tv;
   logic stall_prev;
   cmd_t stall_obs;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic push_pass(input int ihn, input int iwn, input int khn, input int kwn,
                            input int sh, input int sw, input int ph, input int pw,
                            input int ci, input int co);
      int   ohn, own, nh, nw;
      bit   v;
      cmd_t e;
      ohn = (ihn - 1) * sh - 2 * ph + khn;
      own = (iwn - 1) * sw - 2 * pw + kwn;
      for (int oc = 0; oc < co; oc++)
         for (int oh = 0; oh < ohn; oh++)
            for (int ow = 0; ow < own; ow++)
               for (int ic = 0; ic < ci; ic++)
                  for (int kh = 0; kh < khn; kh++)
                     for (int kw = 0; kw < kwn; kw++) begin
                        nh = oh + ph - kh;
                        nw = ow + pw - kw;
                        v  = (nh >= 0) && (nw >= 0) && (nh % sh == 0) && (nw % sw == 0);
                        if (v) v = (nh / sh < ihn) && (nw / sw < iwn);
                        e.in_a  = v ? AW'((ic * ihn + nh / sh) * iwn + nw / sw) : '0;
                        e.w_a   = AW'(((ic * co + oc) * khn + kh) * kwn + kw);
                        e.out_a = AW'((oc * ohn + oh) * own + ow);
                        e.tv    = v;
                        e.first = (ic == 0) && (kh == 0) && (kw == 0);
                        e.last  = (ic == ci - 1) && (kh == khn - 1) && (kw == kwn - 1);
                        exp_q.push_back(e);
                     end
   endtask

   task automatic push_cfg(input int s);
      case (s)
         0:       push_pass(4, 4, 3, 3, 2, 2, 1, 1, 2, 2);
         1:       push_pass(2, 3, 3, 2, 2, 1, 1, 0, 1, 1);
         default: push_pass(2, 2, 1, 2, 1, 4, 0, 0, 1, 1);
      endcase
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (m_done) done_cnt++;
         if (stall_prev && m_valid) check("stall_hold", 64'(obs), 64'(stall_obs));
         stall_prev = m_valid && !cmd_ready;
         stall_obs  = obs;
         if (m_valid && cmd_ready) begin
            check("sb_underflow", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check($sformatf("cmd%0d", hs_cnt), 64'(obs), 64'(exp_q.pop_front()));
            if (hs_cnt < 6) first6[hs_cnt] = obs;
            any_tv = obs.first ? obs.tv : (any_tv | obs.tv);
            if (obs.last && !any_tv) empty_cnt++;
            hs_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      hs_cnt    = 0;
      done_cnt  = 0;
      empty_cnt = 0;
      any_tv    = 1'b0;
   endtask

   task automatic pulse_start(input int s);
      start_v[s] = 1'b1;
      tick();
      start_v[s] = 1'b0;
   endtask

   task automatic run_to_done(input string tag, input int limit, input bit rand_ready,
                              output int cyc);
      cyc = 1;
      while (!m_done && cyc < limit) begin
         if (rand_ready) cmd_ready = ($urandom_range(0, 3) != 0);
         tick();
         cyc++;
      end
      cmd_ready = 1'b1;
      check({tag, "_timeout"}, 64'(m_done), 64'd1);
   endtask

   task automatic check_pass_end(input string tag, input int n_cmd);
      tick();
      tick();
      check({tag, "_count"}, 64'(hs_cnt), 64'(n_cmd));
      check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_idle"}, 64'({m_busy, m_valid, m_done}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cyc;
      rst = 1'b1; abort = 1'b0; cmd_ready = 1'b0; start_v = '0; sel = 0;
      stall_prev = 1'b0;
      clear_counts();
      repeat (3) tick();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("rst_flags%0d", s), 64'({m_busy, m_done, m_valid}), 64'd0);
         check($sformatf("rst_cmd%0d", s), 64'(obs), 64'd0);
      end
      rst = 1'b0;
      tick();

      // reference sequence
      sel = 1; cmd_ready = 1'b1; clear_counts(); push_cfg(1);
      pulse_start(1);
      check("ref_busy", 64'({m_busy, m_valid}), 64'b11);
      run_to_done("ref", 500, 1'b0, cyc);
      check("ref_done_cycle", 64'(cyc), 64'd73);
      check_pass_end("ref", 72);
      check("ref_c0_tv", 64'(first6[0].tv), 64'd0);
      check("ref_c0_in", 64'(first6[0].in_a), 64'd0);
      check("ref_c0_first", 64'(first6[0].first), 64'd1);
      check("ref_c2_tv", 64'(first6[2].tv), 64'd1);
      check("ref_c2_in", 64'(first6[2].in_a), 64'd0);
      check("ref_c2_w", 64'(first6[2].w_a), 64'd2);
      check("ref_c5_last", 64'(first6[5].last), 64'd1);
      check("ref_c5_out", 64'(first6[5].out_a), 64'd0);

      // golden model, random back-pressure
      sel = 0; clear_counts(); push_cfg(0);
      pulse_start(0);
      run_to_done("gold", 20000, 1'b1, cyc);
      check_pass_end("gold", 1764);

      // empty pixels
      sel = 2; clear_counts(); push_cfg(2);
      pulse_start(2);
      run_to_done("empty", 500, 1'b0, cyc);
      check_pass_end("empty", 24);
      check("empty_pixels", 64'(empty_cnt), 64'd4);

      // stall on the final command
      sel = 1; clear_counts(); push_cfg(1);
      pulse_start(1);
      cyc = 0;
      while (exp_q.size() != 1 && cyc < 200) begin
         tick();
         cyc++;
      end
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_done_low", 64'(m_done), 64'd0);
         check("stall_valid", 64'({m_valid, obs.last}), 64'b11);
      end
      cmd_ready = 1'b1;
      run_to_done("stall", 10, 1'b0, cyc);
      repeat (3) tick();
      check("stall_count", 64'(hs_cnt), 64'd72);
      check("stall_done_pulses", 64'(done_cnt), 64'd1);

      // abort mid-pass, then start+abort together
      sel = 0; clear_counts(); push_cfg(0);
      pulse_start(0);
      repeat (30) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_out", 64'({m_busy, m_valid, m_done}), 64'd0);
      exp_q.delete();
      tick();
      check("abort_idle", 64'({m_busy, m_valid, m_done}), 64'd0);
      start_v[0] = 1'b1; abort = 1'b1;
      tick();
      start_v[0] = 1'b0; abort = 1'b0;
      check("start_abort_out", 64'({m_busy, m_valid}), 64'd0);
      repeat (3) tick();
      check("start_abort_idle", 64'({m_busy, m_valid}), 64'd0);
      check("abort_no_done", 64'(done_cnt), 64'd0);
      clear_counts(); push_cfg(0);
      pulse_start(0);
      run_to_done("restart", 3000, 1'b0, cyc);
      check_pass_end("restart", 1764);

      // start pulses during RUN are ignored
      sel = 1; clear_counts(); push_cfg(1);
      pulse_start(1);
      repeat (5) tick();
      pulse_start(1);
      repeat (10) tick();
      pulse_start(1);
      run_to_done("restart_ign", 500, 1'b0, cyc);
      check_pass_end("restart_ign", 72);

      // reset mid-pass
      clear_counts(); push_cfg(1);
      pulse_start(1);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      check("midrst_flags", 64'({m_busy, m_done, m_valid}), 64'd0);
      check("midrst_cmd", 64'(obs), 64'd0);
      exp_q.delete();
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
